conv5x7: RTL and testbench
==========================

Name: conv5x7

Overview:
- Streaming 5-column x 7-row 2-D convolution (dot-product) engine targeting 300 MHz.
- Holds 35 programmable signed coefficients, written through a simple address/data/write port.
- On each push, multiplies a 35-sample window by the coefficients, sums the products, and emits one 45-bit result a fixed number of cycles later.
- Fully pipelined: accepts one window per clock.

Parameters:
- NTAP, 35, number of taps (7 rows x 5 columns).
- SW, 40, sample width (signed).
- CW, 33, coefficient width (signed, CFRAC fractional bits).
- CFRAC, 32, coefficient fractional bits.
- RW, 45, result width.
- LAT, 5, push-to-pushout latency in clocks.

Ports:
- clk in 1: single clock, all state updates on posedge.
- reset in 1: active-high, asynchronous.
- ca in 6: coefficient address, 0..34.
- cd in 33: coefficient data, signed.
- cw in 1: coefficient write strobe.
- push_samp in 1: window valid; samples are captured this edge.
- samp00..samp64 in 40 each: 35 signed samples, named samp<row><col> with row 0..6 and col 0..4; tap index k = row*5+col.
- pushout out 1: result valid, one cycle per accepted push.
- res out 45: result.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset: all 35 coefficients = 0; all pipeline valid bits = 0; pushout = 0; res = 0.
- Coefficient write: on posedge with cw=1 and ca<35, coef[ca] <= cd. ca>=35 is ignored; no state changes.
- Capture: on posedge with push_samp=1, all 35 samples are registered.
- Same-edge write: a coefficient written on the same edge as a push IS used by that push.
  - Implementation: stage 1 multiplies registered samples by the coefficient registers after that edge.
  - Products are registered at the following edge. Later writes never affect a window already captured.
- Arithmetic:
  - p_k = samp_k (signed 40) * coef_k (signed 33), full 73-bit signed product.
  - S = sum of all 35 p_k in full precision (>= 79 bits signed, no overflow).
  - res = S arithmetic-shifted right by CFRAC (floor toward minus infinity), low 45 bits taken (two's-complement wrap).
- Latency and throughput:
  - Push at edge E0 -> pushout=1 with res valid for exactly one cycle after edge E0+LAT.
  - Pushes may occur on consecutive cycles; results appear in order, one per push, no gaps inserted, no backpressure.
- Pipeline: 35 multipliers -> adder tree split across remaining stages. A valid bit shifts alongside the data.
- Outputs pushout and res are driven directly from flops (no combinational path from inputs).
- res holds its last value while pushout=0.
- Reset mid-operation: in-flight windows are discarded; no pushout after reset deasserts until a new push.
- Idle: no push -> pushout stays 0; coefficient writes alone never produce pushout.

Decomposition:
- Package conv5x7_pkg:
  - localparams NTAP, SW, CW, CFRAC, RW, LAT, PW=SW+CW.
  - typedefs samp_t (signed [39:0]), coef_t (signed [32:0]), prod_t (signed [72:0]), acc_t (signed [79:0]).
  - function for the index k = row*5+col.
- One sub-module, conv5x7_row: 5 registered multipliers plus a registered 5-input sum for one row. It is instantiated 7 times. The top-level sums the 7 row results, shifts, and registers the output.

Test Plan:
- Reset: hold reset 3 clocks -> pushout=0, res=0, no X on outputs. Push with all coefficients zero, samp00=1000 -> res=0 at LAT.
- Single tap: write coef[0]=33'h080000000 (0.5), samp00=100, all other samples 0, push -> res=50, pushout exactly one cycle, 5 cycles after push.
- Negative: coef[1]=33'h100000000 (-1.0), samp01=7 -> res=45'h1FFFFFFFFFF9. Same coefficient with samp01=-3 -> res=3.
- Same-edge write: coef[34]=0, then push with samp64=10 while writing coef[34]=33'h040000000 (0.25) on the same edge -> res=2 (floor of 2.5). A write on the next cycle does not change that result.
- Back-to-back: 4 consecutive pushes with samp22=1,2,3,4 and coef[12]=33'h0FFFFFFFF -> 4 consecutive pushout cycles, res=0,1,2,3 (floor of x*(1-2^-32)), in order.
- Reset mid-flight: push, assert reset 2 cycles later -> no pushout ever appears for that window; outputs are 0 and coefficients read back as 0 via a subsequent push.

Source files
------------

// File: rtl/conv5x7_pkg.sv
// conv5x7_pkg: shared widths, types and tap indexing for the
// 5-column x 7-row streaming convolution engine.
package conv5x7_pkg;

    localparam int NTAP  = 35;
    localparam int NROW  = 7;
    localparam int NCOL  = 5;
    localparam int SW    = 40;
    localparam int CW    = 33;
    localparam int CFRAC = 32;
    localparam int RW    = 45;
    localparam int LAT   = 5;
    localparam int PW    = SW + CW;
    // Row sums and the grand total share one width; 35 full products
    // need at most 79 bits, so 80 leaves a spare sign bit.
    localparam int AW    = PW + 7;

    typedef logic signed [SW-1:0] samp_t;
    typedef logic signed [CW-1:0] coef_t;
    typedef logic signed [PW-1:0] prod_t;
    typedef logic signed [AW-1:0] acc_t;

    function automatic int tap_index(input int row, input int col);
        return row * NCOL + col;
    endfunction

endpackage

// File: rtl/conv5x7_row.sv
// conv5x7_row: one row of the window -- 5 registered multipliers
// followed by a registered 5-input sum.
// Ports:
//   clk, reset : clock, async active-high reset
//   samp       : 5 packed signed samples, column 0 in the low bits
//   coef       : 5 packed signed coefficients, same packing
//   sum        : registered full-precision row sum (2 clocks after inputs)
module conv5x7_row
    import conv5x7_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NCOL*SW-1:0] samp,
    input  logic [NCOL*CW-1:0] coef,
    output logic [AW-1:0]     sum
);

    prod_t prod [NCOL];
    acc_t  sum_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCOL; c++) begin
                prod[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCOL; c++) begin
                // Widen both operands first so the multiply is done
                // at full product width with sign extension.
                prod[c] <= prod_t'(samp_t'(samp[c*SW +: SW]))
                         * prod_t'(coef_t'(coef[c*CW +: CW]));
            end
        end
    end

    always_comb begin
        sum_c = '0;
        for (int c = 0; c < NCOL; c++) begin
            sum_c = sum_c + acc_t'(prod[c]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else begin
            sum <= sum_c;
        end
    end

endmodule

// File: rtl/conv5x7.sv
// conv5x7: streaming 5x7 dot-product engine with programmable
// coefficients; one window per clock, result LAT clocks after push.
// Ports:
//   clk, reset     : clock, async active-high reset
//   ca, cd, cw     : coefficient address / data / write strobe
//   push_samp      : window valid, samples captured this edge
//   samp00..samp64 : samples, samp<row><col>, tap k = row*5+col
//   pushout, res   : result valid and registered result
module conv5x7
    import conv5x7_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    ca,
    input  logic [CW-1:0] cd,
    input  logic          cw,
    input  logic          push_samp,
    input  logic [SW-1:0] samp00,
    input  logic [SW-1:0] samp01,
    input  logic [SW-1:0] samp02,
    input  logic [SW-1:0] samp03,
    input  logic [SW-1:0] samp04,
    input  logic [SW-1:0] samp10,
    input  logic [SW-1:0] samp11,
    input  logic [SW-1:0] samp12,
    input  logic [SW-1:0] samp13,
    input  logic [SW-1:0] samp14,
    input  logic [SW-1:0] samp20,
    input  logic [SW-1:0] samp21,
    input  logic [SW-1:0] samp22,
    input  logic [SW-1:0] samp23,
    input  logic [SW-1:0] samp24,
    input  logic [SW-1:0] samp30,
    input  logic [SW-1:0] samp31,
    input  logic [SW-1:0] samp32,
    input  logic [SW-1:0] samp33,
    input  logic [SW-1:0] samp34,
    input  logic [SW-1:0] samp40,
    input  logic [SW-1:0] samp41,
    input  logic [SW-1:0] samp42,
    input  logic [SW-1:0] samp43,
    input  logic [SW-1:0] samp44,
    input  logic [SW-1:0] samp50,
    input  logic [SW-1:0] samp51,
    input  logic [SW-1:0] samp52,
    input  logic [SW-1:0] samp53,
    input  logic [SW-1:0] samp54,
    input  logic [SW-1:0] samp60,
    input  logic [SW-1:0] samp61,
    input  logic [SW-1:0] samp62,
    input  logic [SW-1:0] samp63,
    input  logic [SW-1:0] samp64,
    output logic          pushout,
    output logic [RW-1:0] res
);

    samp_t samp_in [NTAP];
    samp_t samp_q  [NTAP];
    coef_t coef_q  [NTAP];

    logic [NCOL*SW-1:0] row_samp [NROW];
    logic [NCOL*CW-1:0] row_coef [NROW];
    acc_t               row_sum  [NROW];

    logic [LAT-1:0] valid;
    acc_t           part_lo;
    acc_t           part_hi;
    acc_t           total;
    logic           unused_total;

    assign samp_in[0]  = samp00;
    assign samp_in[1]  = samp01;
    assign samp_in[2]  = samp02;
    assign samp_in[3]  = samp03;
    assign samp_in[4]  = samp04;
    assign samp_in[5]  = samp10;
    assign samp_in[6]  = samp11;
    assign samp_in[7]  = samp12;
    assign samp_in[8]  = samp13;
    assign samp_in[9]  = samp14;
    assign samp_in[10] = samp20;
    assign samp_in[11] = samp21;
    assign samp_in[12] = samp22;
    assign samp_in[13] = samp23;
    assign samp_in[14] = samp24;
    assign samp_in[15] = samp30;
    assign samp_in[16] = samp31;
    assign samp_in[17] = samp32;
    assign samp_in[18] = samp33;
    assign samp_in[19] = samp34;
    assign samp_in[20] = samp40;
    assign samp_in[21] = samp41;
    assign samp_in[22] = samp42;
    assign samp_in[23] = samp43;
    assign samp_in[24] = samp44;
    assign samp_in[25] = samp50;
    assign samp_in[26] = samp51;
    assign samp_in[27] = samp52;
    assign samp_in[28] = samp53;
    assign samp_in[29] = samp54;
    assign samp_in[30] = samp60;
    assign samp_in[31] = samp61;
    assign samp_in[32] = samp62;
    assign samp_in[33] = samp63;
    assign samp_in[34] = samp64;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NTAP; k++) begin
                samp_q[k] <= '0;
            end
        end else if (push_samp) begin
            for (int k = 0; k < NTAP; k++) begin
                samp_q[k] <= samp_in[k];
            end
        end
    end

    // Addresses 35..63 match no tap, so they fall through untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NTAP; k++) begin
                coef_q[k] <= '0;
            end
        end else if (cw) begin
            for (int k = 0; k < NTAP; k++) begin
                if (ca == 6'(k)) begin
                    coef_q[k] <= cd;
                end
            end
        end
    end

    // Multipliers read the coefficient registers after the capture
    // edge, so a write on the push edge is seen by that window.
    for (genvar r = 0; r < NROW; r++) begin : g_row
        for (genvar c = 0; c < NCOL; c++) begin : g_col
            assign row_samp[r][c*SW +: SW] = samp_q[tap_index(r, c)];
            assign row_coef[r][c*CW +: CW] = coef_q[tap_index(r, c)];
        end

        conv5x7_row u_row (
            .clk   (clk),
            .reset (reset),
            .samp  (row_samp[r]),
            .coef  (row_coef[r]),
            .sum   (row_sum[r])
        );
    end

    // valid[0]: samples held, [1]: products, [2]: row sums,
    // [3]: partial sums, [4]: total; pushout follows one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid   <= '0;
            part_lo <= '0;
            part_hi <= '0;
            total   <= '0;
            pushout <= 1'b0;
            res     <= '0;
        end else begin
            valid   <= {valid[LAT-2:0], push_samp};
            part_lo <= row_sum[0] + row_sum[1]
                     + row_sum[2] + row_sum[3];
            part_hi <= row_sum[4] + row_sum[5] + row_sum[6];
            total   <= part_lo + part_hi;
            pushout <= valid[LAT-1];
            if (valid[LAT-1]) begin
                // Arithmetic shift by CFRAC then wrap to RW bits.
                res <= total[CFRAC +: RW];
            end
        end
    end

    // Fraction bits and headroom dropped by the shift and wrap.
    assign unused_total = ^{total[AW-1:CFRAC+RW], total[CFRAC-1:0]};

endmodule

// File: tb/tb_conv5x7.sv
// tb_conv5x7: directed scoreboard bench for conv5x7.
// Stimulus queues expected results; a negedge monitor checks them.
module tb_conv5x7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  ca = '0;
    logic [32:0] cd = '0;
    logic        cw = 1'b0;
    logic        push_samp = 1'b0;
    logic [39:0] s [35];
    logic        pushout;
    logic [44:0] res;

    typedef struct {
        logic [44:0] val;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        q [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [44:0] last_res = '0;

    conv5x7 dut (
        .clk(clk), .reset(reset), .ca(ca), .cd(cd), .cw(cw),
        .push_samp(push_samp),
        .samp00(s[0]),  .samp01(s[1]),  .samp02(s[2]),
        .samp03(s[3]),  .samp04(s[4]),  .samp10(s[5]),
        .samp11(s[6]),  .samp12(s[7]),  .samp13(s[8]),
        .samp14(s[9]),  .samp20(s[10]), .samp21(s[11]),
        .samp22(s[12]), .samp23(s[13]), .samp24(s[14]),
        .samp30(s[15]), .samp31(s[16]), .samp32(s[17]),
        .samp33(s[18]), .samp34(s[19]), .samp40(s[20]),
        .samp41(s[21]), .samp42(s[22]), .samp43(s[23]),
        .samp44(s[24]), .samp50(s[25]), .samp51(s[26]),
        .samp52(s[27]), .samp53(s[28]), .samp54(s[29]),
        .samp60(s[30]), .samp61(s[31]), .samp62(s[32]),
        .samp63(s[33]), .samp64(s[34]),
        .pushout(pushout), .res(res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every negedge, either a result is due, or outputs
    // must be quiet and res must hold its previous value.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            checks++;
            if (pushout !== 1'b0 || res !== '0) begin
                errors++;
                $display("FAIL reset_out: pushout=%b res=%h, required 0 and 0",
                         pushout, res);
            end
            last_res = '0;
        end else if (pushout === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pushout: cyc=%0d res=%h, required no pushout",
                         cyc, res);
            end else begin
                e = q.pop_front();
                if (res !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL %s: res=%h at cyc %0d, required %h at cyc %0d",
                             e.name, res, cyc, e.val, e.cyc);
                end
            end
            last_res = res;
        end else begin
            checks++;
            if (pushout !== 1'b0 || res !== last_res) begin
                errors++;
                $display("FAIL idle_hold: pushout=%b res=%h, required 0 and %h",
                         pushout, res, last_res);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_s();
        for (int i = 0; i < 35; i++) s[i] = '0;
    endtask

    task automatic wr(input int a, input logic [32:0] d);
        ca = 6'(a);
        cd = d;
        cw = 1'b1;
        tick();
        cw = 1'b0;
    endtask

    // Capture happens at the next edge (cyc+1); result shows LAT later.
    task automatic push(input logic [44:0] v, input string nm);
        exp_t e;
        e.val  = v;
        e.cyc  = cyc + 6;
        e.name = nm;
        q.push_back(e);
        push_samp = 1'b1;
        tick();
        push_samp = 1'b0;
    endtask

    initial begin
        clear_s();
        #1 reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        s[0] = 40'd1000;
        push(45'd0, "zero_coef");

        wr(0, 33'h080000000);
        clear_s();
        s[0] = 40'd100;
        push(45'd50, "half_tap");

        wr(1, 33'h100000000);
        clear_s();
        s[1] = 40'd7;
        push(45'h1FFFFFFFFFF9, "neg_coef");
        clear_s();
        s[1] = 40'hFFFFFFFFFD;
        push(45'd3, "neg_times_neg");

        clear_s();
        s[0] = 40'hFFFFFFFFFF;
        push(45'h1FFFFFFFFFFF, "floor_neg");
        clear_s();
        s[0] = 40'h8000000000;
        push(45'h1FC000000000, "min_sample");

        // Address 35 must not alias onto tap 3.
        wr(35, 33'h080000000);
        clear_s();
        s[3] = 40'd1000;
        push(45'd0, "ca_out_of_range");

        wr(34, 33'h000000000);
        clear_s();
        s[34] = 40'd10;
        ca = 6'd34;
        cd = 33'h040000000;
        cw = 1'b1;
        push(45'd2, "same_edge_write");
        cd = 33'h0FFFFFFFF;
        tick();
        cw = 1'b0;
        push(45'd9, "after_next_write");

        wr(12, 33'h0FFFFFFFF);
        clear_s();
        for (int i = 1; i <= 4; i++) begin
            s[12] = 40'(i);
            push(45'(i - 1), "back_to_back");
        end

        clear_s();
        s[0]  = 40'd100;
        s[1]  = 40'd7;
        s[12] = 40'd4;
        s[34] = 40'd10;
        push(45'd56, "multi_row");

        clear_s();
        for (int i = 0; i < 5; i++) wr(5 + i, 33'h000000001);
        repeat (10) tick();

        s[0] = 40'd100;
        push(45'd50, "discarded");
        tick();
        reset = 1'b1;
        q.delete();
        repeat (2) tick();
        reset = 1'b0;
        repeat (12) tick();

        s[0]  = 40'd100;
        s[1]  = 40'd7;
        s[12] = 40'd4;
        s[34] = 40'd10;
        push(45'd0, "coef_cleared");

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        repeat (3) tick();
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: no pushout seen, required %h at cyc %0d",
                     e.name, e.val, e.cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
